// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator serialising {rw, addr[6:0], data[7:0]} frames MSB first
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       spi_ncs,
    output logic       spi_copi,
    output logic       spi_sclk
);
    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic          ncs_q, ncs_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Each phase counts cnt down to zero; the last cycle of a phase is where the next one is set up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    shift_d   = {req_rw, req_addr, req_data};
                    bit_cnt_d = '0;
                    cnt_d     = SETUP_LD;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    copi_d    = req_rw;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                copi_d = shift_q[15];
                if (cnt_q == '0) begin
                    state_d = SHIFT_LO;
                    cnt_d   = DIV_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT_LO: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT_HI;
                    cnt_d   = DIV_LD;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == '0) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q != 4'd15) begin
                        state_d   = SHIFT_LO;
                        cnt_d     = DIV_LD;
                        shift_d   = {shift_q[14:0], 1'b0};
                        copi_d    = shift_q[14];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = IDLE_LD;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                copi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign spi_ncs   = ncs_q;
    assign spi_copi  = copi_q;
    assign spi_sclk  = sclk_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - scoreboard bench for spi_controller with a behavioural register-write peripheral
module tb_spi_controller;
    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NL-1:0]      req_valid;
    logic [NL-1:0]      req_rw;
    logic [NL-1:0][6:0] req_addr;
    logic [NL-1:0][7:0] req_data;
    wire  [NL-1:0]      req_ready, busy, done, ncs, copi, sclk;

    always #5 clk = ~clk;

    // Lane 0 runs the default timing, lane 1 the fastest legal divider/setup/hold.
    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int DIV = (g == 0) ? 4 : 2;
        localparam int SH  = (g == 0) ? 2 : 1;
        spi_controller #(
            .CLK_DIV (DIV),
            .CS_SETUP(SH),
            .CS_HOLD (SH),
            .CS_IDLE (4)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_rw   (req_rw[g]),
            .req_addr (req_addr[g]),
            .req_data (req_data[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .spi_ncs  (ncs[g]),
            .spi_copi (copi[g]),
            .spi_sclk (sclk[g])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    logic [16:0] exp_q[$];
    logic [7:0]  regs[NL][5];
    logic [15:0] m_bits[NL];
    int          m_rise[NL], m_low[NL], m_hi[NL], m_gap[NL], m_done_cnt[NL];
    logic        m_prev_ncs[NL], m_prev_sclk[NL];
    bit          abort_pend[NL];

    function automatic int exp_low(input int l);
        return (l == 0) ? 132 : 66;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic frame_end(input int l);
        logic [16:0] e;
        if (abort_pend[l]) begin
            check($sformatf("abort_no_done_l%0d", l), done[l], 1'b0);
            abort_pend[l] = 1'b0;
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame_l%0d: actual=%04h required=none", l, m_bits[l]);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("frame_lane_l%0d", l), l, e[16]);
            check($sformatf("frame_bits_l%0d", l), m_bits[l], e[15:0]);
            check($sformatf("sclk_rises_l%0d", l), m_rise[l], 16);
            check($sformatf("ncs_low_len_l%0d", l), m_low[l], exp_low(l));
            check($sformatf("done_at_ncs_rise_l%0d", l), done[l], 1'b1);
            if (m_bits[l][15] && m_rise[l] == 16 && m_bits[l][14:8] < 7'd5)
                regs[l][m_bits[l][10:8]] = m_bits[l][7:0];
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                if (done[l]) m_done_cnt[l]++;
                if (!ncs[l]) begin
                    if (m_prev_ncs[l]) begin
                        m_gap[l]  = m_hi[l];
                        m_low[l]  = 0;
                        m_rise[l] = 0;
                        m_bits[l] = '0;
                    end
                    m_low[l]++;
                    if (sclk[l] && !m_prev_sclk[l]) begin
                        m_bits[l] = {m_bits[l][14:0], copi[l]};
                        m_rise[l]++;
                    end
                end else begin
                    if (!m_prev_ncs[l]) begin
                        frame_end(l);
                        m_hi[l] = 0;
                    end
                    m_hi[l]++;
                end
                m_prev_ncs[l]  = ncs[l];
                m_prev_sclk[l] = sclk[l];
            end
        end
    endtask

    // Leaves req_valid high; since_done is cycles from a seen done pulse to acceptance (-1 if none).
    task automatic send(input int l, input logic rw, input logic [6:0] a, input logic [7:0] d,
                        input bit push, output int since_done);
        int n;
        int dseen;
        n = 0;
        dseen = -1;
        since_done = -1;
        @(negedge clk);
        req_valid[l] = 1'b1;
        req_rw[l]    = rw;
        req_addr[l]  = a;
        req_data[l]  = d;
        while (!req_ready[l] && n < 2000) begin
            if (done[l]) dseen = 0;
            else if (dseen >= 0) dseen++;
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout_l%0d: actual=not_ready required=ready", l);
            req_valid[l] = 1'b0;
            return;
        end
        if (dseen >= 0) since_done = dseen + 1;
        @(posedge clk);
        if (push) exp_q.push_back({l[0], rw, a, d});
        #1;
        check($sformatf("busy_after_accept_l%0d", l), {busy[l], req_ready[l]}, 2'b10);
    endtask

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy[l] || !req_ready[l]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_timeout_l%0d: actual=busy required=idle", l);
        end
    endtask

    initial begin
        int sd;
        int sd2;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int l = 0; l < NL; l++) begin
            for (int r = 0; r < 5; r++) regs[l][r] = 8'h00;
            m_prev_ncs[l]  = 1'b1;
            m_prev_sclk[l] = 1'b0;
            m_bits[l]      = '0;
            abort_pend[l]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        // Idle after reset: {ncs, sclk, copi, ready, busy, done}
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++)
                check($sformatf("idle_pins_l%0d", l),
                      {ncs[l], sclk[l], copi[l], req_ready[l], busy[l], done[l]}, 6'b100100);
        end

        // Basic frame; request fields are scrambled after acceptance and must not leak in.
        send(0, 1'b1, 7'h00, 8'hA5, 1'b1, sd);
        req_valid[0] = 1'b0;
        req_rw[0]    = 1'b0;
        req_addr[0]  = 7'h7F;
        req_data[0]  = 8'h00;
        wait_idle(0);

        send(0, 1'b1, 7'h04, 8'h80, 1'b1, sd);
        req_valid[0] = 1'b0;
        wait_idle(0);
        send(0, 1'b1, 7'h02, 8'hFF, 1'b1, sd);
        req_valid[0] = 1'b0;
        wait_idle(0);
        check("reg_out_7_0", regs[0][0], 8'hA5);
        check("reg_out_15_8", regs[0][1], 8'h00);
        check("reg_pwm_7_0", regs[0][2], 8'hFF);
        check("reg_pwm_15_8", regs[0][3], 8'h00);
        check("reg_pwm_duty", regs[0][4], 8'h80);

        // Back-to-back with req_valid held high
        send(0, 1'b1, 7'h01, 8'h3C, 1'b1, sd);
        send(0, 1'b1, 7'h03, 8'hC3, 1'b1, sd2);
        req_valid[0] = 1'b0;
        wait_idle(0);
        check("b2b_accept_after_done", sd2, 4);
        check("b2b_ncs_gap", m_gap[0], 5);
        check("b2b_reg_out_15_8", regs[0][1], 8'h3C);
        check("b2b_reg_pwm_15_8", regs[0][3], 8'hC3);

        // Asynchronous reset in the middle of bit 7
        abort_pend[0] = 1'b1;
        send(0, 1'b1, 7'h04, 8'h11, 1'b0, sd);
        req_valid[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("pre_reset_in_frame", {ncs[0], busy[0]}, 2'b01);
        #2 rst_n = 1'b0;
        #1 check("async_reset_pins", {ncs[0], sclk[0], copi[0], busy[0], done[0]}, 5'b10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {req_ready[0], busy[0], ncs[0]}, 3'b101);
        send(0, 1'b1, 7'h00, 8'h5A, 1'b1, sd);
        req_valid[0] = 1'b0;
        wait_idle(0);
        check("post_reset_reg_out_7_0", regs[0][0], 8'h5A);
        check("aborted_write_dropped", regs[0][4], 8'h80);
        check("abort_seen", abort_pend[0], 1'b0);

        // Fast timing, read frame: sent verbatim but must not write the peripheral
        send(1, 1'b0, 7'h00, 8'hFF, 1'b1, sd);
        req_valid[1] = 1'b0;
        wait_idle(1);
        check("fast_read_no_write", regs[1][0], 8'h00);

        check("done_count_l0", m_done_cnt[0], 6);
        check("done_count_l1", m_done_cnt[1], 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
